wb_queue: RTL and testbench
===========================

Name: wb_queue

Overview:
- Writer-side front end for the register file: buffers destination writes from the ALU and memory result paths in a small in-order FIFO.
- Drains one entry per cycle onto the register-file write port (RW/wEn/busW).
- Exposes pending-write lookup and youngest-value forwarding for two read addresses, so decode can bypass writes still queued.
- Sits between the execute/memory stages and the register file.

Parameters:
DEPTH, 4, FIFO entries (power of two, >=2)
AW, 5, register address width
DW, 32, data width

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
alu_valid  in  1  ALU result offered
alu_rd  in  AW  ALU destination register
alu_data  in  DW  ALU result
alu_ready  out  1  ALU offer accepted this cycle when alu_valid high
mem_valid  in  1  load result offered
mem_rd  in  AW  load destination register
mem_data  in  DW  load result
mem_ready  out  1  load offer accepted this cycle when mem_valid high
wb_hold  in  1  freeze draining
RW  out  AW  register-file write address
wEn  out  1  register-file write enable
busW  out  DW  register-file write data
q_ra  in  AW  lookup address A
q_rb  in  AW  lookup address B
fwd_a_hit  out  1  queued write to q_ra exists
fwd_a_data  out  DW  youngest queued value for q_ra
fwd_b_hit  out  1  same for q_rb
fwd_b_data  out  DW  same for q_rb
count  out  clog2(DEPTH)+1  occupied entries
empty  out  1  count==0

Behaviour:
- Reset (reset low, async): head, tail and count clear to 0; all entry valid bits clear. Outputs after reset: wEn=0, RW=0, busW=0, empty=1, count=0, fwd_*_hit=0, fwd_*_data=0.
- Storage: circular buffer of {rd, data}. Head and tail pointers wrap modulo DEPTH.
- Handshake: a transfer occurs when valid && ready on the same rising edge. Producers hold rd/data stable until accepted.
- Ready (combinational; uses count at the start of the cycle, no dequeue credit):
  - mem_ready = (count <= DEPTH-1).
  - alu_ready = (count <= DEPTH-2) when a mem store is also occurring this cycle; otherwise alu_ready = (count <= DEPTH-1).
- Enqueue order when both producers transfer in the same cycle: mem entry first (older instruction), ALU entry second.
- rd==0: the offer is accepted with ready=1 when space allows, but it is not stored and does not consume a slot or count toward space.
- Drain outputs (combinational from the head entry):
  - wEn = !empty && !wb_hold.
  - RW and busW = head rd/data when !empty; 0 when empty.
  - The head pops on the edge where wEn=1, giving one register-file write per cycle.
- Latency: an entry accepted into an empty queue at edge N appears on RW/wEn in cycle N+1. Back-to-back throughput is 1 write per cycle.
- Simultaneous enqueue and dequeue: count_next = count + enq_n - deq (enq_n in 0..2). A full queue with a dequeue in the same cycle still refuses offers that cycle.
- Forwarding (combinational):
  - Scan all valid entries including the head; hit if entry rd == q_r* and q_r* != 0.
  - Data = youngest matching entry, i.e. closest to tail.
  - Entries enqueued in the current cycle are not visible until the next cycle.
  - q_r*==0: hit=0, data=0.
- Boundary cases:
  - Full: both readies low until the next pop.
  - Empty with wb_hold: no effect.
  - Reset mid-operation discards all queued writes; no partial write is issued.
  - Pointer wrap-around is transparent to order and forwarding.
- No X may propagate on any output when empty.

Decomposition:
- Shared package cpu_pkg:
  - REG_AW=5, XLEN=32, REG_ZERO=0 constants.
  - wb_entry_t typedef {valid, rd, data}.
- Natural sub-module: wb_fwd_lookup, a parameterized youngest-match priority search over DEPTH entries given the head pointer. Instantiated twice (ports A and B).

Test Plan:
- Single write: after reset, mem_valid=1, mem_rd=5, mem_data=0x1234 for one cycle -> next cycle wEn=1, RW=5, busW=0x1234; following cycle empty=1, wEn=0.
- Dual enqueue ordering: in one cycle mem (rd=3, 0xAAAA) and alu (rd=4, 0xBBBB) -> both readies 1, count=2; drained writes are RW=3 then RW=4 on consecutive cycles.
- Full/backpressure: wb_hold=1, enqueue 4 distinct writes -> count=4, mem_ready=0, alu_ready=0; drop wb_hold -> 4 writes in 4 cycles, FIFO order preserved, readies return once count<=3.
- Forwarding youngest: queue rd=7 with 0x1, then rd=7 with 0x2 while wb_hold=1; set q_ra=7 -> fwd_a_hit=1, fwd_a_data=0x2; set q_rb=0 -> fwd_b_hit=0.
- rd=0 and wrap: 10 alternating offers with rd=0 and rd=1..5 under random wb_hold -> rd=0 offers accepted, never written, never hit; the 5 nonzero writes appear in order across pointer wrap.
- Async reset mid-stream: reset low with 3 entries queued -> same cycle wEn=0, empty=1, count=0; after release no stale writes are issued.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared core constants and the write-back queue entry layout.
package cpu_pkg;

    localparam int unsigned REG_AW = 5;
    localparam int unsigned XLEN   = 32;
    localparam logic [REG_AW-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fwd_lookup.sv
// Youngest-match search over the queued writes, walking from head (oldest) towards tail.
module wb_fwd_lookup
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = REG_AW,
    parameter int unsigned DW    = XLEN
) (
    input  wb_entry_t                  entries [DEPTH],
    input  logic [$clog2(DEPTH)-1:0]   head,
    input  logic [AW-1:0]              addr,
    output logic                       hit,
    output logic [DW-1:0]              data
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [PW-1:0] idx;

    // Later (younger) matches overwrite earlier ones, so the last hit wins.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        idx  = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = head + PW'(i);
            if (addr != AW'(0) && entries[idx].valid && AW'(entries[idx].rd) == addr) begin
                hit  = 1'b1;
                data = DW'(entries[idx].data);
            end
        end
    end

endmodule

// File: rtl/wb_queue.sv
// In-order write-back FIFO between the ALU/load result paths and the register-file write port,
// with pending-write forwarding for two decode read addresses.
module wb_queue
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = REG_AW,
    parameter int unsigned DW    = XLEN
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     alu_valid,
    input  logic [AW-1:0]            alu_rd,
    input  logic [DW-1:0]            alu_data,
    output logic                     alu_ready,
    input  logic                     mem_valid,
    input  logic [AW-1:0]            mem_rd,
    input  logic [DW-1:0]            mem_data,
    output logic                     mem_ready,
    input  logic                     wb_hold,
    output logic [AW-1:0]            RW,
    output logic                     wEn,
    output logic [DW-1:0]            busW,
    input  logic [AW-1:0]            q_ra,
    input  logic [AW-1:0]            q_rb,
    output logic                     fwd_a_hit,
    output logic [DW-1:0]            fwd_a_data,
    output logic                     fwd_b_hit,
    output logic [DW-1:0]            fwd_b_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    wb_entry_t     entries [DEPTH];
    logic [PW-1:0] head, tail, head_next, tail_next, alu_slot;
    logic [CW-1:0] count_next;
    logic          mem_store, alu_store, deq;

    // Handshake, pointer and occupancy next-state; rd==0 offers are accepted but never stored.
    always_comb begin
        mem_ready  = (count <= CW'(DEPTH - 1));
        mem_store  = mem_valid && mem_ready && (REG_AW'(mem_rd) != REG_ZERO);
        alu_ready  = mem_store ? (count <= CW'(DEPTH - 2)) : (count <= CW'(DEPTH - 1));
        alu_store  = alu_valid && alu_ready && (REG_AW'(alu_rd) != REG_ZERO);
        deq        = (count != '0) && !wb_hold;
        head_next  = deq ? head + PW'(1) : head;
        alu_slot   = tail + PW'(mem_store);
        tail_next  = tail + PW'(mem_store) + PW'(alu_store);
        count_next = count + CW'(mem_store) + CW'(alu_store) - CW'(deq);
    end

    // Drain port is driven straight from the head entry, forced to zero when empty.
    always_comb begin
        empty = (count == '0);
        wEn   = deq;
        RW    = '0;
        busW  = '0;
        if (!empty) begin
            RW   = AW'(entries[head].rd);
            busW = DW'(entries[head].data);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
        end else begin
            head  <= head_next;
            tail  <= tail_next;
            count <= count_next;
            if (deq) begin
                entries[head].valid <= 1'b0;
            end
            // Load result is the older instruction, so it takes the first free slot.
            if (mem_store) begin
                entries[tail] <= '{valid: 1'b1, rd: REG_AW'(mem_rd), data: XLEN'(mem_data)};
            end
            if (alu_store) begin
                entries[alu_slot] <= '{valid: 1'b1, rd: REG_AW'(alu_rd), data: XLEN'(alu_data)};
            end
        end
    end

    wb_fwd_lookup #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_fwd_a (
        .entries (entries),
        .head    (head),
        .addr    (q_ra),
        .hit     (fwd_a_hit),
        .data    (fwd_a_data)
    );

    wb_fwd_lookup #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_fwd_b (
        .entries (entries),
        .head    (head),
        .addr    (q_rb),
        .hit     (fwd_b_hit),
        .data    (fwd_b_data)
    );

endmodule

// File: tb/tb_wb_queue.sv
// Scoreboard bench for wb_queue: directed offers push expected register-file writes,
// a negedge monitor pops and compares every drained write.
module tb_wb_queue;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned AW    = 5;
    localparam int unsigned DW    = 32;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   alu_valid, mem_valid, wb_hold;
    logic [AW-1:0]          alu_rd, mem_rd, q_ra, q_rb;
    logic [DW-1:0]          alu_data, mem_data;
    logic                   alu_ready, mem_ready, wEn, empty;
    logic [AW-1:0]          RW;
    logic [DW-1:0]          busW, fwd_a_data, fwd_b_data;
    logic                   fwd_a_hit, fwd_b_hit;
    logic [$clog2(DEPTH):0] count;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [AW-1:0] rd;
        logic [DW-1:0] data;
    } wr_t;

    wr_t exp_q[$];

    wb_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk        (clk),
        .reset      (reset),
        .alu_valid  (alu_valid),
        .alu_rd     (alu_rd),
        .alu_data   (alu_data),
        .alu_ready  (alu_ready),
        .mem_valid  (mem_valid),
        .mem_rd     (mem_rd),
        .mem_data   (mem_data),
        .mem_ready  (mem_ready),
        .wb_hold    (wb_hold),
        .RW         (RW),
        .wEn        (wEn),
        .busW       (busW),
        .q_ra       (q_ra),
        .q_rb       (q_rb),
        .fwd_a_hit  (fwd_a_hit),
        .fwd_a_data (fwd_a_data),
        .fwd_b_hit  (fwd_b_hit),
        .fwd_b_data (fwd_b_data),
        .count      (count),
        .empty      (empty)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    task automatic push(input logic [AW-1:0] rd, input logic [DW-1:0] d);
        wr_t e;
        e.rd   = rd;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_empty();
        for (int i = 0; i < 40 && empty !== 1'b1; i++) tick();
        check("drain_empty", 32'(empty), 32'd1);
    endtask

    // Hold an ALU offer until accepted, randomising wb_hold each cycle.
    task automatic offer_alu(input logic [AW-1:0] rd, input logic [DW-1:0] d);
        logic accepted;
        accepted  = 1'b0;
        alu_valid = 1'b1;
        alu_rd    = rd;
        alu_data  = d;
        for (int n = 0; n < 50 && !accepted; n++) begin
            wb_hold = 1'($urandom_range(0, 1));
            #1;
            check("zero_never_hits", 32'(fwd_a_hit), 32'd0);
            accepted = alu_ready;
            tick();
        end
        alu_valid = 1'b0;
        check("alu_accept", 32'(accepted), 32'd1);
    endtask

    // Monitor: every cycle with wEn high must match the oldest expected write.
    always @(negedge clk) begin
        wr_t e;
        if (reset === 1'b1 && wEn === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_write: RW=%0d busW=0x%0h with no write expected", RW, busW);
            end else begin
                e = exp_q.pop_front();
                if (RW !== e.rd || busW !== e.data) begin
                    bad++;
                    $display("FAIL drain_order: RW=%0d busW=0x%0h expected RW=%0d busW=0x%0h",
                             RW, busW, e.rd, e.data);
                end
            end
        end
    end

    initial begin
        reset     = 1'b0;
        alu_valid = 1'b0;
        mem_valid = 1'b0;
        wb_hold   = 1'b0;
        alu_rd    = '0;
        mem_rd    = '0;
        alu_data  = '0;
        mem_data  = '0;
        q_ra      = 5'd3;
        q_rb      = 5'd4;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_count", 32'(count), 32'd0);
        check("rst_wen", 32'(wEn), 32'd0);
        check("rst_rw", 32'(RW), 32'd0);
        check("rst_busw", busW, 32'd0);
        check("rst_hit_a", 32'(fwd_a_hit), 32'd0);
        check("rst_data_a", fwd_a_data, 32'd0);
        check("rst_hit_b", 32'(fwd_b_hit), 32'd0);
        check("rst_data_b", fwd_b_data, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        tick();

        // Single write
        mem_valid = 1'b1; mem_rd = 5'd5; mem_data = 32'h1234;
        #1;
        check("single_mem_ready", 32'(mem_ready), 32'd1);
        push(5'd5, 32'h1234);
        tick();
        mem_valid = 1'b0;
        check("single_count", 32'(count), 32'd1);
        check("single_wen", 32'(wEn), 32'd1);
        tick();
        check("single_empty", 32'(empty), 32'd1);
        check("single_wen_off", 32'(wEn), 32'd0);

        // Dual enqueue ordering
        mem_valid = 1'b1; mem_rd = 5'd3; mem_data = 32'hAAAA;
        alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'hBBBB;
        #1;
        check("dual_mem_ready", 32'(mem_ready), 32'd1);
        check("dual_alu_ready", 32'(alu_ready), 32'd1);
        push(5'd3, 32'hAAAA);
        push(5'd4, 32'hBBBB);
        tick();
        mem_valid = 1'b0; alu_valid = 1'b0;
        check("dual_count", 32'(count), 32'd2);
        tick();
        check("dual_count_after_pop", 32'(count), 32'd1);
        check("dual_second_rw", 32'(RW), 32'd4);
        tick();
        check("dual_empty", 32'(empty), 32'd1);

        // Full / backpressure
        wb_hold   = 1'b1;
        mem_valid = 1'b1; mem_rd = 5'd8;  mem_data = 32'h80;
        alu_valid = 1'b1; alu_rd = 5'd9;  alu_data = 32'h90;
        push(5'd8, 32'h80);
        push(5'd9, 32'h90);
        tick();
        mem_rd = 5'd10; mem_data = 32'hA0;
        alu_rd = 5'd11; alu_data = 32'hB0;
        #1;
        check("fill_mem_ready", 32'(mem_ready), 32'd1);
        check("fill_alu_ready", 32'(alu_ready), 32'd1);
        push(5'd10, 32'hA0);
        push(5'd11, 32'hB0);
        tick();
        mem_valid = 1'b0; alu_valid = 1'b0;
        #1;
        check("full_count", 32'(count), 32'd4);
        check("full_mem_ready", 32'(mem_ready), 32'd0);
        check("full_alu_ready", 32'(alu_ready), 32'd0);
        mem_valid = 1'b1; mem_rd = 5'd12; mem_data = 32'hC0;
        wb_hold   = 1'b0;
        #1;
        check("full_deq_refuse", 32'(mem_ready), 32'd0);
        check("full_deq_wen", 32'(wEn), 32'd1);
        tick();
        check("after_pop_count", 32'(count), 32'd3);
        check("after_pop_ready", 32'(mem_ready), 32'd1);
        push(5'd12, 32'hC0);
        tick();
        mem_valid = 1'b0;
        check("enq_deq_count", 32'(count), 32'd3);
        wait_empty();

        // Forwarding youngest
        wb_hold = 1'b1;
        q_ra = 5'd7; q_rb = 5'd0;
        mem_valid = 1'b1; mem_rd = 5'd7; mem_data = 32'h1;
        #1;
        check("fwd_none_yet", 32'(fwd_a_hit), 32'd0);
        push(5'd7, 32'h1);
        tick();
        mem_data = 32'h2;
        #1;
        check("fwd_old_hit", 32'(fwd_a_hit), 32'd1);
        check("fwd_same_cycle_invisible", fwd_a_data, 32'h1);
        push(5'd7, 32'h2);
        tick();
        mem_valid = 1'b0;
        #1;
        check("fwd_young_hit", 32'(fwd_a_hit), 32'd1);
        check("fwd_young_data", fwd_a_data, 32'h2);
        check("fwd_zero_hit", 32'(fwd_b_hit), 32'd0);
        check("fwd_zero_data", fwd_b_data, 32'd0);
        q_rb = 5'd7;
        #1;
        check("fwd_b_data", fwd_b_data, 32'h2);
        q_rb = 5'd9;
        #1;
        check("fwd_b_miss", 32'(fwd_b_hit), 32'd0);
        wb_hold = 1'b0;
        tick();
        check("fwd_after_pop", fwd_a_data, 32'h2);
        wait_empty();
        check("fwd_gone", 32'(fwd_a_hit), 32'd0);

        // rd=0 interleaved with real writes, across pointer wrap
        q_ra = 5'd0; q_rb = 5'd0;
        for (int k = 1; k <= 5; k++) begin
            offer_alu(5'd0, 32'hDEAD0000 + 32'(k));
            push(5'(k), 32'h100 + 32'(k));
            offer_alu(5'(k), 32'h100 + 32'(k));
        end
        wb_hold = 1'b0;
        wait_empty();

        // Async reset mid-stream
        wb_hold   = 1'b1;
        mem_valid = 1'b1; mem_rd = 5'd20; mem_data = 32'h20;
        alu_valid = 1'b1; alu_rd = 5'd21; alu_data = 32'h21;
        tick();
        alu_valid = 1'b0;
        mem_rd = 5'd22; mem_data = 32'h22;
        tick();
        mem_valid = 1'b0;
        check("pre_reset_count", 32'(count), 32'd3);
        wb_hold = 1'b0;
        reset   = 1'b0;
        #1;
        check("mid_reset_wen", 32'(wEn), 32'd0);
        check("mid_reset_empty", 32'(empty), 32'd1);
        check("mid_reset_count", 32'(count), 32'd0);
        check("mid_reset_rw", 32'(RW), 32'd0);
        repeat (2) tick();
        reset = 1'b1;
        repeat (6) tick();
        check("post_reset_empty", 32'(empty), 32'd1);

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
